// File: rtl/global_defs.sv
// Shared types for the trace-driven DRAM front end.
// Parser opcodes, address width and request-queue types.
package global_defs;

  localparam int ADDRESS_WIDTH = 34;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } parsed_op_t;

  typedef enum logic [1:0] {
    Q_EMPTY  = 2'd0,
    Q_ACTIVE = 2'd1,
    Q_FULL   = 2'd2
  } queue_state_t;

  typedef struct packed {
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
  } queue_entry_t;

endpackage

// File: rtl/request_queue.sv
// In-order request queue between the trace parser and DRAM scheduler.
// Ports: clk, rst_n (sync, active low); op_ready_s/opcode/address from
// the parser (captured on strobe rising edge); req_* valid/ready head
// view; req_age head age; count/full/empty/overflow status; state debug.
// Build option: define REQUEST_QUEUE_AGE_EN for per-entry age counters.
module request_queue
  import global_defs::*;
#(
  parameter int DEPTH     = 16,
  parameter int AGE_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_ready_s,
  input  parsed_op_t               opcode,
  input  logic [ADDRESS_WIDTH-1:0] address,
  output logic                     req_valid,
  output parsed_op_t               req_opcode,
  output logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic                     req_ready,
  output logic [AGE_WIDTH-1:0]     req_age,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output queue_state_t             state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  queue_entry_t   mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count_nxt;
  logic           strobe_q;
  logic           enq;
  logic           deq;
  logic           accept;
  logic           drop;
  queue_state_t   state_nxt;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign enq    = op_ready_s & ~strobe_q & (opcode != NOP);
  assign deq    = req_valid & req_ready;
  // When full, a same-cycle dequeue frees the slot being written.
  assign accept = enq & (~full | deq);
  assign drop   = enq & full & ~deq;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign req_valid   = ~empty;
  assign req_opcode  = empty ? NOP : mem[head].opcode;
  assign req_address = empty ? '0 : mem[head].address;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      accept & ~deq: count_nxt = count + 1'b1;
      deq & ~accept: count_nxt = count - 1'b1;
      default:       count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      strobe_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      strobe_q <= op_ready_s;
      count    <= count_nxt;
      if (accept) tail <= ptr_inc(tail);
      if (deq)    head <= ptr_inc(head);
      if (drop)   overflow <= 1'b1;
    end
  end

  // Storage is not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      mem[tail].opcode  <= opcode;
      mem[tail].address <= address;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= Q_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      Q_EMPTY: begin
        if (accept)
          state_nxt = (count_nxt == CW'(DEPTH)) ? Q_FULL : Q_ACTIVE;
      end
      Q_ACTIVE: begin
        if (count_nxt == '0)
          state_nxt = Q_EMPTY;
        else if (count_nxt == CW'(DEPTH))
          state_nxt = Q_FULL;
      end
      Q_FULL: begin
        if (count_nxt != CW'(DEPTH))
          state_nxt = Q_ACTIVE;
      end
      default: state_nxt = Q_EMPTY;
    endcase
  end

`ifdef REQUEST_QUEUE_AGE_EN
  logic [DEPTH-1:0]     vld;
  logic [AGE_WIDTH-1:0] age [DEPTH];

  // A write to a slot wins over the head clear on the same slot
  // (full with simultaneous enqueue and dequeue).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && tail == PW'(i)) begin
          vld[i] <= 1'b1;
          age[i] <= '0;
        end else if (deq && head == PW'(i)) begin
          vld[i] <= 1'b0;
        end else if (vld[i] && age[i] != '1) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  assign req_age = empty ? '0 : age[head];
`else
  assign req_age = '0;
`endif

endmodule
